// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one result buffer per functional unit, round-robin
// selection of up to CDB_SIZE buffered results per cycle onto the broadcast slots.
package cdb_pkg;
  typedef struct packed {
    logic        valid;
    logic [5:0]  rd_paddr;
    logic [31:0] data;
    logic [4:0]  rob_tag;
  } CDB_t;
endpackage

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned CDB_SIZE = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  input  CDB_t               req_data [NUM_REQ],
  output logic [NUM_REQ-1:0] req_ready,
  output CDB_t               CDB [CDB_SIZE],
  input  logic               flush
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  CDB_t                buf_q [NUM_REQ];
  logic [NUM_REQ-1:0]  buf_v_q;
  logic [PtrW-1:0]     rr_ptr_q;
  logic [PtrW-1:0]     rr_ptr_d;

  logic                active;
  logic [NUM_REQ-1:0]  grant;
  logic                any_grant;
  logic [PtrW-1:0]     last_idx;
  logic [PtrW-1:0]     idx;
  int                  used;

  // Grants are suppressed entirely during reset and flush, which also freezes rr_ptr.
  assign active = rst && !flush;

  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    last_idx  = '0;
    idx       = '0;
    used      = 0;
    for (int k = 0; k < int'(CDB_SIZE); k++) begin
      CDB[k] = '0;
    end
    for (int p = 0; p < int'(NUM_REQ); p++) begin
      idx = PtrW'((int'(rr_ptr_q) + p) % int'(NUM_REQ));
      if (active && buf_v_q[idx] && (used < int'(CDB_SIZE))) begin
        grant[idx] = 1'b1;
        any_grant  = 1'b1;
        last_idx   = idx;
        for (int k = 0; k < int'(CDB_SIZE); k++) begin
          if (used == k) begin
            CDB[k]       = buf_q[idx];
            CDB[k].valid = 1'b1;
          end
        end
        used = used + 1;
      end
    end
  end

  // A granted buffer drains this cycle, so it can take a new result at the same edge.
  assign req_ready = {NUM_REQ{active}} & (~buf_v_q | grant);

  always_comb begin
    if (int'(last_idx) == int'(NUM_REQ) - 1) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = last_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_v_q  <= '0;
      rr_ptr_q <= '0;
    end else if (flush) begin
      buf_v_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (req_valid[i] && req_ready[i]) begin
          buf_v_q[i] <= 1'b1;
        end else if (grant[i]) begin
          buf_v_q[i] <= 1'b0;
        end
      end
      if (any_grant) begin
        rr_ptr_q <= rr_ptr_d;
      end
    end
  end

  // Payload storage needs no reset; buf_v_q alone qualifies it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (req_valid[i] && req_ready[i]) begin
        buf_q[i] <= req_data[i];
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus random traffic
// compared every cycle against a scan-list reference model.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int N  = 4;
  localparam int S  = 2;
  localparam int VW = N + S * $bits(CDB_t);

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_ready;
  CDB_t         req_data [N];
  CDB_t         cdb [S];

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(N), .CDB_SIZE(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .CDB      (cdb),
    .flush    (flush)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: buffers as plain arrays, grants as a list built by walking
  // the requesters starting from the pointer.
  CDB_t         mbuf [N];
  bit           mv [N];
  int           mrr = 0;
  CDB_t         exp_cdb [S];
  logic [N-1:0] exp_ready;
  logic [N-1:0] eg;
  int           elast;

  function automatic void model_eval();
    int n;
    int i;
    n     = 0;
    eg    = '0;
    elast = -1;
    for (int k = 0; k < S; k++) exp_cdb[k] = '0;
    if (rst && !flush) begin
      for (int p = 0; p < N; p++) begin
        i = (mrr + p) % N;
        if (mv[i] && n < S) begin
          eg[i]              = 1'b1;
          exp_cdb[n]         = mbuf[i];
          exp_cdb[n].valid   = 1'b1;
          n++;
          elast = i;
        end
      end
    end
    for (int j = 0; j < N; j++) exp_ready[j] = rst && !flush && (!mv[j] || eg[j]);
  endfunction

  function automatic void model_edge();
    if (!rst) begin
      for (int i = 0; i < N; i++) mv[i] = 1'b0;
      mrr = 0;
    end else if (flush) begin
      for (int i = 0; i < N; i++) mv[i] = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && exp_ready[i]) begin
          mbuf[i] = req_data[i];
          mv[i]   = 1'b1;
        end else if (eg[i]) begin
          mv[i] = 1'b0;
        end
      end
      if (elast >= 0) mrr = (elast + 1) % N;
    end
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    CDB_t a;
    CDB_t b;
    a = cdb[0];
    b = cdb[1];
    if (!a.valid) a = '0;
    if (!b.valid) b = '0;
    return {req_ready, b, a};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {exp_ready, exp_cdb[1], exp_cdb[0]};
  endfunction

  function automatic CDB_t rand_payload();
    CDB_t p;
    p.valid    = 1'($urandom);
    p.rd_paddr = 6'($urandom);
    p.data     = $urandom;
    p.rob_tag  = 5'($urandom);
    return p;
  endfunction

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    flush     = 1'b0;
    for (int i = 0; i < N; i++) req_data[i] = rand_payload();
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    idle_inputs();
    settle();
    advance();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      flush     = 1'($urandom);
      req_valid = 4'($urandom);
      for (int i = 0; i < N; i++) req_data[i] = rand_payload();
      settle();
      total++;
      if (req_ready !== 4'h0 || cdb[0].valid !== 1'b0 || cdb[1].valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold ready=%b v0=%b v1=%b want ready=0000 v0=0 v1=0",
                 req_ready, cdb[0].valid, cdb[1].valid);
      end
      advance();
    end
    rst = 1'b1;
    idle_inputs();
    settle();
    total++;
    if (req_ready !== 4'hf || cdb[0].valid !== 1'b0 || cdb[1].valid !== 1'b0
        || dut.rr_ptr_q !== 2'd0) begin
      bad++;
      $display("FAIL reset_release ready=%b v0=%b v1=%b rr=%0d want ready=1111 v=0 rr=0",
               req_ready, cdb[0].valid, cdb[1].valid, dut.rr_ptr_q);
    end
    advance();
  endtask

  task automatic test_single();
    apply_reset();
    req_valid            = 4'b0001;
    req_data[0].rd_paddr = 6'd5;
    settle();
    advance();
    req_valid = '0;
    settle();
    total++;
    if (cdb[0].valid !== 1'b1 || cdb[0].rd_paddr !== 6'd5 || cdb[1].valid !== 1'b0
        || obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL single v0=%b pa0=%0d v1=%b want v0=1 pa0=5 v1=0",
               cdb[0].valid, cdb[0].rd_paddr, cdb[1].valid);
    end
    advance();
    total++;
    if (dut.rr_ptr_q !== 2'd1) begin
      bad++;
      $display("FAIL single_rr got=%0d want=1", dut.rr_ptr_q);
    end
  endtask

  task automatic test_contention();
    apply_reset();
    req_valid            = 4'b0111;
    req_data[0].rd_paddr = 6'd3;
    req_data[1].rd_paddr = 6'd7;
    req_data[2].rd_paddr = 6'd9;
    settle();
    advance();
    // div holds a new result while its buffer is still waiting.
    req_valid            = 4'b0100;
    req_data[2]          = rand_payload();
    req_data[2].rd_paddr = 6'd13;
    settle();
    total++;
    if (cdb[0].valid !== 1'b1 || cdb[0].rd_paddr !== 6'd3 || cdb[1].valid !== 1'b1
        || cdb[1].rd_paddr !== 6'd7 || req_ready[2] !== 1'b0 || obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL contention_c1 pa0=%0d pa1=%0d rdy2=%b got=%h want=%h slots 3,7 rdy2=0",
               cdb[0].rd_paddr, cdb[1].rd_paddr, req_ready[2], obs_vec(), exp_vec());
    end
    advance();
    total++;
    if (dut.rr_ptr_q !== 2'd2) begin
      bad++;
      $display("FAIL contention_rr got=%0d want=2", dut.rr_ptr_q);
    end
    settle();
    total++;
    if (cdb[0].valid !== 1'b1 || cdb[0].rd_paddr !== 6'd9 || cdb[1].valid !== 1'b0
        || req_ready[2] !== 1'b1 || obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL contention_c2 v0=%b pa0=%0d v1=%b rdy2=%b want v0=1 pa0=9 v1=0 rdy2=1",
               cdb[0].valid, cdb[0].rd_paddr, cdb[1].valid, req_ready[2]);
    end
    advance();
    req_valid = '0;
    settle();
    total++;
    if (cdb[0].valid !== 1'b1 || cdb[0].rd_paddr !== 6'd13 || cdb[1].valid !== 1'b0) begin
      bad++;
      $display("FAIL contention_c3 v0=%b pa0=%0d v1=%b want v0=1 pa0=13 v1=0",
               cdb[0].valid, cdb[0].rd_paddr, cdb[1].valid);
    end
    advance();
  endtask

  task automatic test_rr_wrap();
    int e0 [3];
    int e1 [3];
    int since [N];
    int worst;
    e0    = '{3, 1, 3};
    e1    = '{0, 2, 0};
    worst = 0;
    for (int i = 0; i < N; i++) since[i] = 0;
    apply_reset();
    // One div result moves rr_ptr to 3 before everyone fills up.
    req_valid            = 4'b0100;
    req_data[2].rd_paddr = 6'd2;
    settle();
    advance();
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) begin
      req_data[i]          = rand_payload();
      req_data[i].rd_paddr = 6'(i);
    end
    settle();
    advance();
    total++;
    if (dut.rr_ptr_q !== 2'd3) begin
      bad++;
      $display("FAIL rr_setup got=%0d want=3", dut.rr_ptr_q);
    end
    for (int c = 0; c < 3; c++) begin
      settle();
      total++;
      if (cdb[0].valid !== 1'b1 || cdb[1].valid !== 1'b1 || cdb[0].rd_paddr !== 6'(e0[c])
          || cdb[1].rd_paddr !== 6'(e1[c]) || obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL rr_wrap c=%0d grants={%0d,%0d} want={%0d,%0d}",
                 c, cdb[0].rd_paddr, cdb[1].rd_paddr, e0[c], e1[c]);
      end
      for (int i = 0; i < N; i++) begin
        if ((cdb[0].valid && cdb[0].rd_paddr == 6'(i))
            || (cdb[1].valid && cdb[1].rd_paddr == 6'(i))) since[i] = 0;
        else since[i]++;
        if (since[i] > worst) worst = since[i];
      end
      advance();
      for (int i = 0; i < N; i++) req_data[i].data = $urandom;
    end
    total++;
    if (worst + 1 > 2) begin
      bad++;
      $display("FAIL rr_fairness worst_wait=%0d want<=2", worst + 1);
    end
    req_valid = '0;
  endtask

  task automatic test_pass_through();
    apply_reset();
    for (int n = 0; n < 6; n++) begin
      if (n < 5) begin
        req_valid            = 4'b1000;
        req_data[3]          = rand_payload();
        req_data[3].rd_paddr = 6'(20 + n);
      end else begin
        req_valid = '0;
      end
      settle();
      total++;
      if ((n < 5 && req_ready[3] !== 1'b1)
          || (n >= 1 && (cdb[0].valid !== 1'b1 || cdb[0].rd_paddr !== 6'(19 + n)))
          || obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL pass_through n=%0d rdy3=%b v0=%b pa0=%0d want rdy3=1 pa0=%0d",
                 n, req_ready[3], cdb[0].valid, cdb[0].rd_paddr, 19 + n);
      end
      advance();
    end
  endtask

  task automatic test_flush();
    apply_reset();
    req_valid = 4'b0111;
    settle();
    advance();
    flush       = 1'b1;
    req_valid   = 4'b0001;
    req_data[0] = rand_payload();
    settle();
    total++;
    if (req_ready !== 4'h0 || cdb[0].valid !== 1'b0 || cdb[1].valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_cycle ready=%b v0=%b v1=%b want ready=0000 v=0",
               req_ready, cdb[0].valid, cdb[1].valid);
    end
    advance();
    idle_inputs();
    settle();
    total++;
    if (req_ready !== 4'hf || cdb[0].valid !== 1'b0 || cdb[1].valid !== 1'b0
        || dut.rr_ptr_q !== 2'd0) begin
      bad++;
      $display("FAIL flush_after ready=%b v0=%b v1=%b rr=%0d want ready=1111 v=0 rr=0",
               req_ready, cdb[0].valid, cdb[1].valid, dut.rr_ptr_q);
    end
    advance();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req_valid = 4'b1010;
    settle();
    advance();
    rst       = 1'b0;
    req_valid = '0;
    settle();
    advance();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      total++;
      if (cdb[0].valid !== 1'b0 || cdb[1].valid !== 1'b0 || dut.rr_ptr_q !== 2'd0) begin
        bad++;
        $display("FAIL reset_mid c=%0d v0=%b v1=%b rr=%0d want v=0 rr=0",
                 c, cdb[0].valid, cdb[1].valid, dut.rr_ptr_q);
      end
      advance();
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 49) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      req_valid = 4'($urandom);
      for (int i = 0; i < N; i++) req_data[i] = rand_payload();
      settle();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL random c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
      advance();
    end
    rst = 1'b1;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_rr_wrap();
    test_pass_through();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
